rom_dl_sequencer: RTL and testbench
===================================

// Module: rom_dl_sequencer
// PURPOSE
//  Sequences the ioctl ROM download into the per-CPU ROM blocks and owns CPU reset.
//  Decodes ioctl_addr into 4 regions and emits a registered one-hot write strobe,
//  a region-relative address and a data byte to the ROM RAMs.
//  Holds cpu_rst high through download plus a settle window, then releases the CPUs.
// PARAMETERS
//  BASE0   27'h00000  region 0 start (main CPU ROM)
//  BASE1   27'h18000  region 1 start (gfx/aux ROM)
//  BASE2   27'h21000  region 2 start (sub CPU ROM)
//  BASE3   27'h29000  region 3 start (sound/MCU ROM)
//  BASE4   27'h31000  end of region 3, exclusive
//  SETTLE  16         cycles cpu_rst stays high after the last write commits (0..255)
// PORTS
//  clk_sys         in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  ioctl_download  in   1   download in progress
//  ioctl_addr      in   27  byte address of the download stream
//  ioctl_dout      in   16  download data; only [7:0] is used
//  ioctl_wr        in   1   write qualifier, one cycle per byte
//  rom_we          out  4   one-hot write strobe, bit i = region i
//  rom_addr        out  17  ioctl_addr - BASE_i, truncated to 17 bits
//  rom_data        out  8   registered ioctl_dout[7:0]
//  cpu_rst         out  1   CPU reset request, active high
//  dl_done         out  1   high once ROMs are loaded and settled
//  chk_sum         out  32  per-region 8-bit byte sums, {r3,r2,r1,r0}
// BEHAVIOUR
//  Reset values: rom_we=0, rom_addr=0, rom_data=0, cpu_rst=1, dl_done=0, chk_sum=0, state=IDLE.
//  States:
//   IDLE  : cpu_rst=1. ioctl_download=1 -> LOAD.
//   LOAD  : writes accepted. ioctl_download=0 -> FLUSH.
//   FLUSH : one cycle so the final strobe commits. Then HOLD, or RUN if SETTLE=0.
//   HOLD  : counter 0..SETTLE-1; reaching SETTLE-1 -> RUN.
//   RUN   : cpu_rst=0, dl_done=1.
//  Re-download: ioctl_download=1 in FLUSH/HOLD/RUN -> LOAD next cycle. On that same
//   cycle cpu_rst goes high, dl_done drops and the HOLD counter clears.
//  Write accept: ioctl_download & ioctl_wr sampled high while in IDLE or LOAD, with
//   BASE_i <= ioctl_addr < BASE_{i+1}.
//   - The IDLE->LOAD entry cycle counts as accepting.
//   - A write sampled on the same edge that download falls is still accepted.
//  Latency: ioctl_wr accepted at edge N -> rom_we[i]=1 for exactly cycle N+1.
//   rom_addr and rom_data are registered with the strobe and held until the next write.
//  Out-of-range address, or ioctl_wr outside an accepting state: dropped, rom_we stays 0.
//  Back-to-back ioctl_wr on consecutive cycles: one strobe per cycle, no loss.
//   At most one rom_we bit is high in any cycle.
//  Address arithmetic: 27-bit subtraction, low 17 bits kept; regions over 128 KB alias.
//  Reset mid-download: everything returns to reset values. In-flight strobe is squashed.
// CONFIGURATION
//  CHECKSUM_EN defined:
//   - chk_sum[8i+7:8i] += rom_data, mod 256, on every rom_we[i] cycle.
//   - Updated on the cycle after the strobe.
//   - All four sums clear on entry to LOAD.
//  CHECKSUM_EN undefined: chk_sum tied to 32'h0, no adders synthesised.
// TESTING
//  1 Reset then idle 10 cycles -> cpu_rst=1, dl_done=0, rom_we=0.
//  2 Download, wr at addr 27'h21005 with dout 16'h00A5 ->
//    next cycle rom_we=4'b0100, rom_addr=17'h00005, rom_data=8'hA5.
//  3 Writes at 27'h17FFF and 27'h18000 on consecutive cycles ->
//    strobes 4'b0001 then 4'b0010, rom_addr 17'h17FFF then 17'h00000.
//  4 Write at 27'h31000, and a wr with download=0 -> no strobe.
//  5 Drop download with SETTLE=16 -> cpu_rst falls exactly 18 cycles after the
//    falling sample (1 FLUSH + 16 HOLD + 1 transition into RUN), dl_done rises with it.
//    Re-raising download in RUN -> cpu_rst=1 next cycle.
//  6 CHECKSUM_EN: bytes 8'hF0, 8'h20, 8'h01 to region 3 -> chk_sum[31:24]=8'h11.
//    Then reset asserted mid-stream -> chk_sum=0, state IDLE.

Source files
------------

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: region decode, write strobes, CPU reset hold-off.
// Optional per-region byte checksums when CHECKSUM_EN is defined.
module rom_dl_sequencer #(
  parameter logic [26:0] BASE0  = 27'h00000,
  parameter logic [26:0] BASE1  = 27'h18000,
  parameter logic [26:0] BASE2  = 27'h21000,
  parameter logic [26:0] BASE3  = 27'h29000,
  parameter logic [26:0] BASE4  = 27'h31000,
  parameter int          SETTLE = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic        ioctl_wr,
  output logic [3:0]  rom_we,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        cpu_rst,
  output logic        dl_done,
  output logic [31:0] chk_sum
);

  typedef enum logic [2:0] {
    IDLE, LOAD, FLUSH, HOLD, RUN
  } state_t;

  localparam logic [7:0] LAST =
    (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic        r_cpu_rst, r_dl_done;
  logic [3:0]  r_we;
  logic [16:0] r_addr;
  logic [7:0]  r_data;

  logic [26:0] w_off0, w_off1, w_off2, w_off3;
  logic [3:0]  w_hit;
  logic [16:0] w_sel;
  logic        w_accept, w_enter_load, w_stay_run;
  logic        w_unused;

  assign w_unused = ^ioctl_dout[15:8];

  // Wrapping subtract makes each range test a single unsigned compare.
  assign w_off0 = ioctl_addr - BASE0;
  assign w_off1 = ioctl_addr - BASE1;
  assign w_off2 = ioctl_addr - BASE2;
  assign w_off3 = ioctl_addr - BASE3;

  assign w_hit[0] = w_off0 < (BASE1 - BASE0);
  assign w_hit[1] = w_off1 < (BASE2 - BASE1);
  assign w_hit[2] = w_off2 < (BASE3 - BASE2);
  assign w_hit[3] = w_off3 < (BASE4 - BASE3);

  always_comb begin
    w_sel = '0;
    unique case (1'b1)
      w_hit[0]: w_sel = w_off0[16:0];
      w_hit[1]: w_sel = w_off1[16:0];
      w_hit[2]: w_sel = w_off2[16:0];
      w_hit[3]: w_sel = w_off3[16:0];
      default:  w_sel = '0;
    endcase
  end

  assign w_accept = ioctl_wr &&
    ((r_state == IDLE && ioctl_download) ||
     r_state == LOAD);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (ioctl_download) w_next = LOAD;
      LOAD:  if (!ioctl_download) w_next = FLUSH;
      FLUSH: begin
        if (ioctl_download)   w_next = LOAD;
        else if (SETTLE == 0) w_next = RUN;
        else                  w_next = HOLD;
      end
      HOLD: begin
        if (ioctl_download)     w_next = LOAD;
        else if (r_cnt == LAST) w_next = RUN;
      end
      RUN:   if (ioctl_download) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_load = (w_next == LOAD) && (r_state != LOAD);
  assign w_stay_run   = (r_state == RUN) && (w_next == RUN);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cpu_rst <= 1'b1;
      r_dl_done <= 1'b0;
      r_we      <= '0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (r_state == HOLD && w_next == HOLD)
                   ? r_cnt + 8'd1 : 8'd0;
      r_cpu_rst <= !w_stay_run;
      r_dl_done <= w_stay_run;
      r_we      <= w_accept ? w_hit : 4'b0000;
      if (w_accept && |w_hit) begin
        r_addr <= w_sel;
        r_data <= ioctl_dout[7:0];
      end
    end
  end

  assign rom_we   = r_we;
  assign rom_addr = r_addr;
  assign rom_data = r_data;
  assign cpu_rst  = r_cpu_rst;
  assign dl_done  = r_dl_done;

`ifdef CHECKSUM_EN
  logic [7:0] r_sum [4];

  always_ff @(posedge clk_sys) begin
    if (reset || w_enter_load) begin
      for (int i = 0; i < 4; i++) r_sum[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (r_we[i]) r_sum[i] <= r_sum[i] + r_data;
    end
  end

  assign chk_sum = {r_sum[3], r_sum[2], r_sum[1], r_sum[0]};
`else
  assign chk_sum = 32'h0;
`endif

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer.
// Checksum expectations follow CHECKSUM_EN.
module tb_rom_dl_sequencer;

`ifdef CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wr;
  logic [3:0]  rom_we;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        cpu_rst;
  logic        dl_done;
  logic [31:0] chk_sum;

  int checks   = 0;
  int failures = 0;

  rom_dl_sequencer dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .rom_we         (rom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .cpu_rst        (cpu_rst),
    .dl_done        (dl_done),
    .chk_sum        (chk_sum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [26:0] a,
                    input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_wr = 1'b0;
    tick();
    tick();
    chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("rst_dl_done", 32'(dl_done), 32'h0);
    chk("rst_rom_we", 32'(rom_we), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_rom_data", 32'(rom_data), 32'h0);
    chk("rst_chk_sum", chk_sum, 32'h0);
    reset = 1'b0;
    repeat (10) tick();
    chk("idle_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("idle_dl_done", 32'(dl_done), 32'h0);
    chk("idle_rom_we", 32'(rom_we), 32'h0);

    wr(27'h00010, 16'h0055);
    chk("idle_wr_nostrobe", 32'(rom_we), 32'h0);
    chk("idle_wr_addr", 32'(rom_addr), 32'h0);

    ioctl_download = 1'b1;
    wr(27'h21005, 16'h00A5);
    chk("r2_we", 32'(rom_we), 32'h4);
    chk("r2_addr", 32'(rom_addr), 32'h00005);
    chk("r2_data", 32'(rom_data), 32'hA5);
    chk("load_cpu_rst", 32'(cpu_rst), 32'h1);
    ioctl_wr = 1'b0;
    tick();
    chk("one_cycle_we", 32'(rom_we), 32'h0);
    chk("hold_addr", 32'(rom_addr), 32'h00005);
    chk("hold_data", 32'(rom_data), 32'hA5);

    wr(27'h17FFF, 16'hCC11);
    chk("r0_top_we", 32'(rom_we), 32'h1);
    chk("r0_top_addr", 32'(rom_addr), 32'h17FFF);
    chk("r0_top_data", 32'(rom_data), 32'h11);
    wr(27'h18000, 16'h0022);
    chk("r1_base_we", 32'(rom_we), 32'h2);
    chk("r1_base_addr", 32'(rom_addr), 32'h00000);
    wr(27'h28FFF, 16'h0010);
    chk("r2_top_we", 32'(rom_we), 32'h4);
    chk("r2_top_addr", 32'(rom_addr), 32'h07FFF);
    wr(27'h30FFF, 16'h1234);
    chk("r3_top_we", 32'(rom_we), 32'h8);
    chk("r3_top_addr", 32'(rom_addr), 32'h07FFF);
    chk("r3_top_data", 32'(rom_data), 32'h34);
    wr(27'h31000, 16'h0077);
    chk("oor_nostrobe", 32'(rom_we), 32'h0);
    chk("oor_addr_held", 32'(rom_addr), 32'h07FFF);
    chk("oor_data_held", 32'(rom_data), 32'h34);
    ioctl_wr = 1'b0;
    tick();
    chk("sums_load", chk_sum, CK ? 32'h34B52211 : 32'h0);

    ioctl_download = 1'b0;
    tick();
    chk("flush_cpu_rst", 32'(cpu_rst), 32'h1);
    for (int k = 1; k < 18; k++) begin
      tick();
      chk($sformatf("settle_%0d", k), 32'(cpu_rst), 32'h1);
    end
    chk("settle_done_lo", 32'(dl_done), 32'h0);
    tick();
    chk("run_cpu_rst", 32'(cpu_rst), 32'h0);
    chk("run_dl_done", 32'(dl_done), 32'h1);

    wr(27'h00000, 16'h0001);
    chk("run_wr_nostrobe", 32'(rom_we), 32'h0);
    chk("run_cpu_rst2", 32'(cpu_rst), 32'h0);
    ioctl_wr = 1'b0;

    ioctl_download = 1'b1;
    tick();
    chk("redl_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("redl_dl_done", 32'(dl_done), 32'h0);
    chk("redl_sum_clr", chk_sum, 32'h0);

    wr(27'h29000, 16'h00F0);
    chk("cs_we0", 32'(rom_we), 32'h8);
    wr(27'h29001, 16'h0020);
    chk("cs_we1", 32'(rom_we), 32'h8);
    wr(27'h29002, 16'h0001);
    chk("cs_we2", 32'(rom_we), 32'h8);
    chk("cs_addr2", 32'(rom_addr), 32'h00002);
    ioctl_wr = 1'b0;
    tick();
    chk("cs_sum", chk_sum, CK ? 32'h11000000 : 32'h0);

    wr(27'h29003, 16'h00F0);
    chk("pre_rst_we", 32'(rom_we), 32'h8);
    reset = 1'b1;
    wr(27'h29004, 16'h0033);
    chk("mid_rst_we", 32'(rom_we), 32'h0);
    chk("mid_rst_sum", chk_sum, 32'h0);
    chk("mid_rst_addr", 32'(rom_addr), 32'h0);
    chk("mid_rst_cpu", 32'(cpu_rst), 32'h1);
    chk("mid_rst_done", 32'(dl_done), 32'h0);
    reset = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (25) tick();
    chk("post_rst_idle", 32'(cpu_rst), 32'h1);
    chk("post_rst_done", 32'(dl_done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
